// File: rtl/router_pkg.sv
// Shared types and helpers for the 1xN packet router.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        PARITY,
        DROP
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Show-ahead channel FIFO with a synchronous flush that empties it in one edge.
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_wr, do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Flush wins over any write or read in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/router_1xn.sv
// Length-framed 1xN byte router: header/payload/parity framing, out-of-range drop,
// per-channel read-timeout flush and a saturating parity error counter.
module router_1xn
    import router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pkt_valid,
    output logic                     busy,
    input  logic [NUM_CH-1:0]        read_enb,
    output logic [NUM_CH-1:0]        vld_out,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     err,
    output logic                     drop,
    output logic [15:0]              err_count
);

    localparam int ADDR_W = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1;
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int TMO_W  = clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic [DATA_W-1:0]  parity_q, parity_d;
    logic               err_q, err_d;
    logic               drop_q, drop_d;
    logic [15:0]        err_count_q, err_count_d;
    logic [TMO_W-1:0]   tmo_q [NUM_CH];
    logic [TMO_W-1:0]   tmo_d [NUM_CH];

    logic [ADDR_W-1:0]  hdr_addr, dest;
    logic [LEN_W-1:0]   hdr_len;
    logic               dest_ok, dest_full, dest_flush, accept, write_byte;
    logic [NUM_CH-1:0]  full, empty, flush, wr_en;
    logic [DATA_W-1:0]  fifo_dout [NUM_CH];

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[DATA_W-1:ADDR_W];

    // The destination is taken from the incoming header only while idle.
    always_comb begin
        dest       = (state_q == IDLE) ? hdr_addr : addr_q;
        dest_ok    = int'(dest) < NUM_CH;
        dest_full  = 1'b0;
        dest_flush = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (dest == ADDR_W'(i)) begin
                dest_full  = full[i];
                dest_flush = flush[i];
            end
        end
        busy   = pkt_valid && (state_q != DROP) && dest_ok && dest_full;
        accept = pkt_valid && !busy;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        parity_d    = parity_q;
        err_d       = 1'b0;
        drop_d      = 1'b0;
        err_count_d = err_count_q;
        write_byte  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d   = hdr_addr;
                    remain_d = hdr_len;
                    parity_d = data_in;
                    if (!dest_ok || dest_flush) begin
                        state_d = DROP;
                    end else begin
                        write_byte = 1'b1;
                        state_d    = (hdr_len == '0) ? PARITY : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (dest_flush) begin
                    state_d = DROP;
                    if (accept) begin
                        remain_d = remain_q - 1'b1;
                    end
                end else if (accept) begin
                    write_byte = 1'b1;
                    parity_d   = parity_q ^ data_in;
                    remain_d   = remain_q - 1'b1;
                    if (remain_q == LEN_W'(1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (dest_flush) begin
                    if (accept) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end else if (accept) begin
                    write_byte = 1'b1;
                    state_d    = IDLE;
                    if (data_in != parity_q) begin
                        err_d = 1'b1;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    if (remain_q == '0) begin
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        remain_d = remain_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A channel left unread with data waiting for TIMEOUT cycles is flushed.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            flush[i] = (tmo_q[i] == TMO_W'(TIMEOUT));
            wr_en[i] = write_byte && (dest == ADDR_W'(i)) && !flush[i];
            if (flush[i]) begin
                tmo_d[i] = '0;
            end else if (vld_out[i] && !read_enb[i]) begin
                tmo_d[i] = tmo_q[i] + 1'b1;
            end else begin
                tmo_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            parity_q    <= '0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            err_count_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                tmo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            parity_q    <= parity_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            err_count_q <= err_count_d;
            tmo_q       <= tmo_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        router_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clock  (clock),
            .resetn (resetn),
            .flush  (flush[g]),
            .wr_en  (wr_en[g]),
            .rd_en  (read_enb[g]),
            .din    (data_in),
            .dout   (fifo_dout[g]),
            .empty  (empty[g]),
            .full   (full[g])
        );
        assign data_out[g*DATA_W +: DATA_W] = fifo_dout[g];
        assign vld_out[g] = !empty[g];
    end

    assign err       = err_q;
    assign drop      = drop_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_router_1xn.sv
// Directed bench for router_1xn: 3 channels (so address 3 is out of range), 8-deep FIFOs.
module tb_router_1xn;

    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  data_in;
    logic        pkt_valid;
    logic        busy;
    logic [2:0]  read_enb;
    logic [2:0]  vld_out;
    logic [23:0] data_out;
    logic        err;
    logic        drop;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [2:0]  re;
        logic        busy;
        logic [2:0]  vld;
        logic [7:0]  head1;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t       vecs [20];
    logic [7:0] bp_bytes [11];
    logic [7:0] popped [$];

    router_1xn #(
        .DATA_W     (8),
        .NUM_CH     (3),
        .FIFO_DEPTH (8),
        .TIMEOUT    (30)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .busy      (busy),
        .read_enb  (read_enb),
        .vld_out   (vld_out),
        .data_out  (data_out),
        .err       (err),
        .drop      (drop),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic [2:0] re);
        @(negedge clock);
        pkt_valid = v;
        data_in   = d;
        read_enb  = re;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int  idx;
        logic acc;

        // Good packet to ch1 (parity 0D^11^22^33 = 0D), then the same with a bad parity byte.
        vecs[0]  = '{1'b1, 8'h0D, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 8'h11, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 8'h22, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 8'h33, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 8'h0D, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 8'h11, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 8'h22, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 8'h33, 1'b0, 16'd0};
        vecs[8]  = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[9]  = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b000, 8'h00, 1'b0, 16'd0};
        vecs[10] = '{1'b1, 8'h0D, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[11] = '{1'b1, 8'h11, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[12] = '{1'b1, 8'h22, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[13] = '{1'b1, 8'h33, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b0, 16'd0};
        vecs[14] = '{1'b1, 8'h00, 3'b000, 1'b0, 3'b010, 8'h0D, 1'b1, 16'd1};
        vecs[15] = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 8'h11, 1'b0, 16'd1};
        vecs[16] = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 8'h22, 1'b0, 16'd1};
        vecs[17] = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 8'h33, 1'b0, 16'd1};
        vecs[18] = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 8'h00, 1'b0, 16'd1};
        vecs[19] = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b000, 8'h00, 1'b0, 16'd1};

        // Header addr2 len9, payload 01..09, parity 26^01^..^09 = 27.
        bp_bytes[0]  = 8'h26;
        for (int k = 1; k <= 9; k++) bp_bytes[k] = 8'(k);
        bp_bytes[10] = 8'h27;

        resetn    = 1'b0;
        pkt_valid = 1'b0;
        data_in   = '0;
        read_enb  = '0;
        #12;
        check_output("reset vld_out", 32'(vld_out), 32'h0);
        check_output("reset data_out", 32'(data_out), 32'h0);
        check_output("reset busy", 32'(busy), 32'h0);
        check_output("reset err", 32'(err), 32'h0);
        check_output("reset drop", 32'(drop), 32'h0);
        check_output("reset err_count", 32'(err_count), 32'h0);
        @(negedge clock);
        resetn = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i].v, vecs[i].d, vecs[i].re);
            check_output($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            tick();
            check_output($sformatf("vec%0d vld_out", i), 32'(vld_out), 32'(vecs[i].vld));
            check_output($sformatf("vec%0d head1", i), 32'(data_out[15:8]), 32'(vecs[i].head1));
            check_output($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].err));
            check_output($sformatf("vec%0d err_count", i), 32'(err_count), 32'(vecs[i].cnt));
        end

        $display("[TB] back-pressure on ch2");
        idx = 0;
        for (int c = 0; c < 80 && !(idx == 11 && !vld_out[2]); c++) begin
            @(negedge clock);
            pkt_valid = (idx < 11);
            data_in   = (idx < 11) ? bp_bytes[idx] : 8'h00;
            read_enb  = {((c == 10) || (c >= 14)), 2'b00};
            #1;
            if (c == 7) check_output("bp busy before full", 32'(busy), 32'h0);
            if (c == 8) check_output("bp busy when full", 32'(busy), 32'h1);
            if (c == 10) check_output("bp busy during pop", 32'(busy), 32'h1);
            if (c == 11) check_output("bp busy after pop", 32'(busy), 32'h0);
            if (c == 12) check_output("bp busy refilled", 32'(busy), 32'h1);
            if (c == 13) check_output("bp accepted count", 32'(idx), 32'd9);
            if (read_enb[2] && vld_out[2]) popped.push_back(data_out[23:16]);
            acc = pkt_valid && !busy;
            tick();
            if (acc) idx++;
        end
        pkt_valid = 1'b0;
        read_enb  = '0;
        check_output("bp popped count", 32'(popped.size()), 32'd11);
        for (int k = 0; k < popped.size() && k < 11; k++) begin
            check_output($sformatf("bp byte%0d", k), 32'(popped[k]), 32'(bp_bytes[k]));
        end

        $display("[TB] out-of-range drop");
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: apply_stimulus(1'b1, 8'h0B, 3'b000);
                1: apply_stimulus(1'b1, 8'h55, 3'b000);
                2: apply_stimulus(1'b1, 8'h66, 3'b000);
                default: apply_stimulus(1'b1, 8'h77, 3'b000);
            endcase
            check_output($sformatf("drop busy%0d", k), 32'(busy), 32'h0);
            tick();
            check_output($sformatf("drop vld%0d", k), 32'(vld_out), 32'h0);
            check_output($sformatf("drop pulse%0d", k), 32'(drop), 32'(k == 3));
        end
        apply_stimulus(1'b0, 8'h00, 3'b000);
        tick();
        check_output("drop pulse end", 32'(drop), 32'h0);

        $display("[TB] timeout flush on ch0");
        apply_stimulus(1'b1, 8'h00, 3'b000);
        tick();
        check_output("tmo vld after header", 32'(vld_out), 32'h1);
        apply_stimulus(1'b1, 8'h00, 3'b000);
        tick();
        for (int k = 3; k <= 31; k++) begin
            apply_stimulus(1'b0, 8'h00, 3'b000);
            tick();
        end
        check_output("tmo vld before flush", 32'(vld_out), 32'h1);
        apply_stimulus(1'b0, 8'h00, 3'b000);
        tick();
        check_output("tmo vld after flush", 32'(vld_out), 32'h0);
        check_output("tmo data after flush", 32'(data_out), 32'h0);
        apply_stimulus(1'b1, 8'h04, 3'b000);
        tick();
        check_output("tmo new header head", 32'(data_out[7:0]), 32'h04);
        apply_stimulus(1'b1, 8'hAA, 3'b000);
        tick();
        apply_stimulus(1'b1, 8'hAE, 3'b000);
        tick();
        check_output("tmo new err", 32'(err), 32'h0);
        apply_stimulus(1'b0, 8'h00, 3'b001);
        tick();
        check_output("tmo pop1", 32'(data_out[7:0]), 32'hAA);
        apply_stimulus(1'b0, 8'h00, 3'b001);
        tick();
        check_output("tmo pop2", 32'(data_out[7:0]), 32'hAE);
        apply_stimulus(1'b0, 8'h00, 3'b001);
        tick();
        check_output("tmo drained", 32'(vld_out), 32'h0);

        $display("[TB] async reset mid-payload");
        apply_stimulus(1'b1, 8'h0D, 3'b000);
        tick();
        apply_stimulus(1'b1, 8'h11, 3'b000);
        tick();
        check_output("rst pre vld", 32'(vld_out), 32'h2);
        pkt_valid = 1'b0;
        read_enb  = '0;
        #2;
        resetn = 1'b0;
        #1;
        check_output("rst vld_out", 32'(vld_out), 32'h0);
        check_output("rst data_out", 32'(data_out), 32'h0);
        check_output("rst err_count", 32'(err_count), 32'h0);
        check_output("rst busy", 32'(busy), 32'h0);
        check_output("rst err", 32'(err), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        apply_stimulus(1'b1, 8'h09, 3'b000);
        tick();
        check_output("rst new header vld", 32'(vld_out), 32'h2);
        check_output("rst new header head", 32'(data_out[15:8]), 32'h09);
        apply_stimulus(1'b1, 8'h01, 3'b000);
        tick();
        apply_stimulus(1'b1, 8'h02, 3'b000);
        tick();
        apply_stimulus(1'b1, 8'h0A, 3'b000);
        tick();
        check_output("rst new err", 32'(err), 32'h0);
        check_output("rst new vld", 32'(vld_out), 32'h2);
        apply_stimulus(1'b0, 8'h00, 3'b010);
        tick();
        check_output("rst pop1", 32'(data_out[15:8]), 32'h01);
        apply_stimulus(1'b0, 8'h00, 3'b010);
        tick();
        check_output("rst pop2", 32'(data_out[15:8]), 32'h02);
        apply_stimulus(1'b0, 8'h00, 3'b010);
        tick();
        check_output("rst pop3", 32'(data_out[15:8]), 32'h0A);
        apply_stimulus(1'b0, 8'h00, 3'b010);
        tick();
        check_output("rst drained", 32'(vld_out), 32'h0);
        check_output("rst err_count end", 32'(err_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_1xn.md
Name: router_1xn

Overview:
- Next-generation packet router: one byte-stream input, NUM_CH output channels, each with its own buffer FIFO.
- Each packet is a header, then a length-defined payload, then a parity byte. The header's address field selects the destination channel.
- New over the fixed 1x3 router:
  - parametrised width, depth and channel count;
  - length-framed packets, so no dependence on pkt_valid timing;
  - drop of packets with an out-of-range address;
  - per-channel read timeout flush;
  - saturating error counter.

Parameters:
- DATA_W, 8, byte width of data_in and data_out (min 4).
- NUM_CH, 4, number of output channels (2..16).
- FIFO_DEPTH, 16, entries per channel FIFO (power of 2, min 4).
- TIMEOUT, 30, cycles a channel may sit with vld_out high and no read before it is flushed.
- Derived localparams: ADDR_W = max(1, clog2(NUM_CH)); LEN_W = DATA_W - ADDR_W.

Ports:
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- data_in  in  DATA_W  packet byte
- pkt_valid  in  1  data_in is valid
- busy  out  1  input back-pressure; a byte transfers when pkt_valid && !busy
- read_enb  in  NUM_CH  per-channel pop
- vld_out  out  NUM_CH  per-channel data available (= !empty)
- data_out  out  NUM_CH*DATA_W  flattened per-channel FIFO head, channel i at [i*DATA_W +: DATA_W]
- err  out  1  one-cycle pulse on parity mismatch
- drop  out  1  one-cycle pulse when an out-of-range packet completes
- err_count  out  16  saturating count of parity errors

Behaviour:
- Reset (async, resetn=0):
  - all FIFOs empty; vld_out=0; data_out=0; busy=0; err=0; drop=0; err_count=0;
  - FSM to IDLE, timeout counters 0.
  - A reset in mid-packet discards everything; the next accepted byte is a header.
- Packet format:
  - header: addr = data_in[ADDR_W-1:0], len = data_in[DATA_W-1:ADDR_W];
  - then len payload bytes, then one parity byte;
  - expected parity = XOR of header and all payload bytes; len=0 is legal (header then parity).
- FSM states and transitions:
  - IDLE: accepted byte is a header. Latch addr and len; running parity = header.
    - addr < NUM_CH: write header to FIFO[addr]; go to PAYLOAD, or to PARITY if len=0.
    - otherwise: go to DROP.
  - PAYLOAD: each accepted byte is written, XORed into parity, decrements remaining; after the last byte go to PARITY.
  - PARITY: accepted byte is written.
    - If it differs from the running parity, err pulses in the following cycle and err_count increments, saturating at 16'hFFFF.
    - Return to IDLE.
  - DROP: consume len payload bytes plus parity with busy=0, nothing written. drop pulses the cycle after the parity byte is consumed; return to IDLE. No parity check in DROP.
- busy (combinational): pkt_valid && destination FIFO full.
  - In IDLE the destination comes from data_in's address field; elsewhere from the latched addr.
  - busy is always 0 in DROP and for out-of-range headers.
  - A simultaneous read does not relieve full within the same cycle.
- Write latency: a byte accepted at edge N is visible on data_out and vld_out after edge N.
- FIFO:
  - show-ahead: data_out shows the head;
  - read_enb[i] pops on the edge when !empty;
  - a read while empty is ignored;
  - simultaneous read and write when not full and not empty keeps the count unchanged;
  - pointers wrap modulo FIFO_DEPTH.
- Timeout flush, per channel:
  - the counter increments each cycle with vld_out[i]=1 && read_enb[i]=0, and clears otherwise.
  - On reaching TIMEOUT, FIFO i is emptied at the next edge and the counter clears.
  - If channel i is the active destination, the rest of the packet switches to DROP. A write in the flush cycle is discarded, and drop pulses at the packet's end.
- An idle gap between bytes (pkt_valid=0) is allowed in any state; the FSM holds.

Decomposition:
- router_pkg: FSM state enum (IDLE, PAYLOAD, PARITY, DROP) and a clog2 function.
- Sub-module router_fifo: parameters DATA_W and DEPTH; ports clock, resetn, flush, wr_en, rd_en, din, dout, empty, full. It is instantiated NUM_CH times in a generate loop.
- The FSM, parity logic and timeout counters live in the top.

Test Plan:
- Basic routing (NUM_CH=4): header 8'h0D (addr1, len3), payload 11,22,33, parity 8'h0D^11^22^33 -> vld_out=4'b0010; five bytes pop in order; err=0.
- Parity error: same packet with parity byte 8'h00 -> err pulses once the cycle after parity; err_count=1; all five bytes are still stored.
- Back-pressure: FIFO_DEPTH=4, read disabled, header addr2 len5 -> busy rises after the 4th write; pulse read_enb[2] once -> exactly one more byte accepted; no byte is lost.
- Out-of-range drop (NUM_CH=3): header 8'h0B (addr3, len2) plus 3 bytes -> busy=0 throughout; vld_out stays 0; drop pulses once.
- Timeout (TIMEOUT=30): write a packet to ch0 and never read -> FIFO 0 empty and vld_out[0]=0 exactly after cycle 30; a new packet to ch0 is then routed normally.
- Async reset mid-payload -> all outputs 0 immediately; the next byte is treated as a header.
